// File: rtl/sys_cmd_decoder.sv
// UART command-frame responder: parses 0xAA write / 0xBB read frames, drives
// register-file strobes, returns read data to UART TX, aborts on errors or timeout.
module sys_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                  REF_CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_ERR,
  output logic                  WR_EN,
  output logic                  RD_EN,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  RD_DATA_VLD,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CMD_ERR,
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] CMD_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD   = DATA_WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_SEND
  } state_t;

  state_t                state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [DATA_WIDTH-1:0] txd_nxt;
  logic                  wr_en_nxt;
  logic                  rd_en_nxt;
  logic                  tx_vld_nxt;
  logic                  cmd_err_nxt;
  logic                  busy_nxt;
  logic                  byte_ok;
  logic                  byte_bad;
  logic                  expired;
  logic                  timed_nxt;

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      WR_EN     <= 1'b0;
      RD_EN     <= 1'b0;
      ADDR      <= '0;
      WR_DATA   <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CMD_ERR   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      WR_EN     <= wr_en_nxt;
      RD_EN     <= rd_en_nxt;
      ADDR      <= addr_nxt;
      WR_DATA   <= wdata_nxt;
      TX_P_DATA <= txd_nxt;
      TX_D_VLD  <= tx_vld_nxt;
      CMD_ERR   <= cmd_err_nxt;
      BUSY      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    addr_nxt    = ADDR;
    wdata_nxt   = WR_DATA;
    txd_nxt     = TX_P_DATA;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    tx_vld_nxt  = 1'b0;
    cmd_err_nxt = 1'b0;
    byte_ok     = RX_D_VLD && !RX_ERR;
    byte_bad    = RX_D_VLD && RX_ERR;
    expired     = (cnt_q == CNT_LAST);

    // In every byte-accepting state a byte (good or bad) takes priority over expiry.
    case (state_q)
      S_IDLE: begin
        if (byte_ok) begin
          if (RX_P_DATA == CMD_WR) begin
            state_nxt = S_WR_ADDR;
          end else if (RX_P_DATA == CMD_RD) begin
            state_nxt = S_RD_ADDR;
          end else begin
            cmd_err_nxt = 1'b1;
          end
        end else if (byte_bad) begin
          cmd_err_nxt = 1'b1;
        end
      end
      S_WR_ADDR: begin
        if (byte_ok) begin
          addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nxt = S_WR_DATA;
        end else if (byte_bad || expired) begin
          cmd_err_nxt = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (byte_ok) begin
          wdata_nxt = RX_P_DATA;
          wr_en_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else if (byte_bad || expired) begin
          cmd_err_nxt = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (byte_ok) begin
          addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_nxt = 1'b1;
          state_nxt = S_RD_WAIT;
        end else if (byte_bad || expired) begin
          cmd_err_nxt = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (RD_DATA_VLD) begin
          txd_nxt   = RD_DATA;
          state_nxt = S_TX_SEND;
        end else if (expired) begin
          cmd_err_nxt = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_TX_SEND: begin
        if (!TX_BUSY) begin
          tx_vld_nxt = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Any state change (entry or accepted byte) restarts the inter-byte count;
    // bytes ignored in RD_WAIT do not change state and so do not restart it.
    timed_nxt = (state_nxt == S_WR_ADDR) || (state_nxt == S_WR_DATA) ||
                (state_nxt == S_RD_ADDR) || (state_nxt == S_RD_WAIT);
    if (timed_nxt && (state_nxt == state_q)) begin
      cnt_nxt = cnt_q + 1'b1;
    end else begin
      cnt_nxt = '0;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Self-checking bench for sys_cmd_decoder: directed vector table, hand-written
// corner sequences, and a randomized frame timeline checked cycle by cycle.
module tb_sys_cmd_decoder;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int TMO  = 20;
  localparam int MAXC = 8000;

  // Strobe/status vector order: {WR_EN, RD_EN, TX_D_VLD, CMD_ERR, BUSY}
  localparam logic [4:0] S_NO = 5'b00000;
  localparam logic [4:0] S_WR = 5'b10000;
  localparam logic [4:0] S_RD = 5'b01000;
  localparam logic [4:0] S_TX = 5'b00100;
  localparam logic [4:0] S_ER = 5'b00010;
  localparam logic [4:0] S_BZ = 5'b00001;

  logic          REF_CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic          RX_ERR;
  logic          WR_EN;
  logic          RD_EN;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] WR_DATA;
  logic [DW-1:0] RD_DATA;
  logic          RD_DATA_VLD;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          TX_BUSY;
  logic          CMD_ERR;
  logic          BUSY;

  always #5 REF_CLK = ~REF_CLK;

  sys_cmd_decoder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .REF_CLK(REF_CLK),
    .RST(RST),
    .RX_P_DATA(RX_P_DATA),
    .RX_D_VLD(RX_D_VLD),
    .RX_ERR(RX_ERR),
    .WR_EN(WR_EN),
    .RD_EN(RD_EN),
    .ADDR(ADDR),
    .WR_DATA(WR_DATA),
    .RD_DATA(RD_DATA),
    .RD_DATA_VLD(RD_DATA_VLD),
    .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD),
    .TX_BUSY(TX_BUSY),
    .CMD_ERR(CMD_ERR),
    .BUSY(BUSY)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic       vld;
    logic       err;
    logic [7:0] d;
    logic       rdv;
    logic [7:0] rdd;
    logic       txb;
    logic [4:0] s;
    logic [3:0] a;
    logic [7:0] w;
    logic [7:0] t;
  } vec_t;
  vec_t vecs[$];

  typedef struct packed {
    logic       vld;
    logic       err;
    logic [7:0] d;
    logic       rdv;
    logic [7:0] rdd;
    logic       txb;
    logic       lk_rdv;
    logic       lk_txb;
  } stim_t;

  stim_t      stim  [MAXC];
  logic [4:0] exp_s [MAXC];
  logic       up_a  [MAXC];
  logic [3:0] up_av [MAXC];
  logic       up_w  [MAXC];
  logic [7:0] up_wv [MAXC];
  logic       up_t  [MAXC];
  logic [7:0] up_tv [MAXC];
  int unsigned gen_end;

  // Drive one cycle of inputs, let the edge sample them, and return #1 later.
  task automatic drive(input logic v, input logic e, input logic [7:0] d,
                       input logic rv, input logic [7:0] rd, input logic tb);
    RX_D_VLD    = v;
    RX_ERR      = e;
    RX_P_DATA   = d;
    RD_DATA_VLD = rv;
    RD_DATA     = rd;
    TX_BUSY     = tb;
    @(posedge REF_CLK);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [4:0] es, input logic [3:0] ea,
                         input logic [7:0] ew, input logic [7:0] et);
    logic [4:0] as;
    as = {WR_EN, RD_EN, TX_D_VLD, CMD_ERR, BUSY};
    checks++;
    if (as !== es || ADDR !== ea || WR_DATA !== ew || TX_P_DATA !== et) begin
      errors++;
      $display("FAIL %s @%0t: wr/rd/tx/err/busy=%b addr=%h wd=%h txd=%h, expected %b addr=%h wd=%h txd=%h",
               nm, $time, as, ADDR, WR_DATA, TX_P_DATA, es, ea, ew, et);
    end
  endtask

  task automatic idle_chk(input int unsigned n, input string nm, input logic [4:0] es,
                          input logic [3:0] ea, input logic [7:0] ew, input logic [7:0] et,
                          input logic tb);
    for (int unsigned i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, tb);
      chk_out($sformatf("%s_%0d", nm, i), es, ea, ew, et);
    end
  endtask

  task automatic row(input logic v, input logic e, input logic [7:0] d, input logic rv,
                     input logic [7:0] rd, input logic tb, input logic [4:0] s,
                     input logic [3:0] a, input logic [7:0] w, input logic [7:0] t);
    vec_t x;
    x = '{vld: v, err: e, d: d, rdv: rv, rdd: rd, txb: tb, s: s, a: a, w: w, t: t};
    vecs.push_back(x);
  endtask

  // ---------------- random timeline generation (frame-level model) ----------------
  task automatic put(input int unsigned j, input logic [7:0] d, input logic e);
    stim[j].vld = 1'b1;
    stim[j].d   = d;
    stim[j].err = e;
  endtask

  task automatic set_busy(input int unsigned a, input int unsigned b);
    for (int unsigned j = a; j <= b; j++) exp_s[j][0] = 1'b1;
  endtask

  task automatic set_addr(input int unsigned j, input logic [7:0] d);
    up_a[j]  = 1'b1;
    up_av[j] = d[3:0];
  endtask

  task automatic gen();
    int unsigned t, e0, e1, e2, r, b, k, n, pos;
    logic [7:0]  d, cmd;
    logic        is_wr;
    for (int unsigned j = 0; j < MAXC; j++) begin
      stim[j]  = '0;
      exp_s[j] = '0;
      up_a[j]  = 1'b0; up_av[j] = '0;
      up_w[j]  = 1'b0; up_wv[j] = '0;
      up_t[j]  = 1'b0; up_tv[j] = '0;
    end
    t = 0;
    while (t < MAXC - 200) begin
      k     = $urandom_range(9, 0);
      e0    = t + $urandom_range(4, 1);
      is_wr = ($urandom_range(1, 0) == 1);
      cmd   = is_wr ? 8'hAA : 8'hBB;
      if (k <= 2) begin
        put(e0, 8'hAA, 1'b0);
        e1 = e0 + $urandom_range(TMO, 1);
        d = 8'($urandom); put(e1, d, 1'b0); set_addr(e1, d);
        e2 = e1 + $urandom_range(TMO, 1);
        d = 8'($urandom); put(e2, d, 1'b0);
        up_w[e2] = 1'b1; up_wv[e2] = d;
        exp_s[e2] |= S_WR;
        set_busy(e0, e2 - 1);
        t = e2;
      end else if (k <= 4) begin
        put(e0, 8'hBB, 1'b0);
        e1 = e0 + $urandom_range(TMO, 1);
        d = 8'($urandom); put(e1, d, 1'b0); set_addr(e1, d);
        exp_s[e1] |= S_RD;
        r = e1 + $urandom_range(TMO, 1);
        for (int unsigned j = e1 + 1; j <= r; j++) stim[j].lk_rdv = 1'b1;
        d = 8'($urandom);
        stim[r].rdv = 1'b1; stim[r].rdd = d;
        up_t[r] = 1'b1; up_tv[r] = d;
        b = ($urandom_range(7, 0) == 0) ? $urandom_range(50, 20) : $urandom_range(3, 0);
        for (int unsigned j = r + 1; j <= r + b + 1; j++) begin
          stim[j].lk_rdv = 1'b1;
          stim[j].lk_txb = 1'b1;
          stim[j].txb    = (j <= r + b);
        end
        exp_s[r + b + 1] |= S_TX;
        set_busy(e0, r + b);
        // Bytes arriving while waiting for data or for TX are ignored.
        for (int unsigned j = e1 + 1; j <= r + b + 1; j++)
          if ($urandom_range(5, 0) == 0) put(j, 8'($urandom), 1'($urandom));
        t = r + b + 1;
      end else if (k == 5) begin
        do d = 8'($urandom); while (d == 8'hAA || d == 8'hBB);
        put(e0, d, 1'b0);
        exp_s[e0] |= S_ER;
        t = e0;
      end else if (k <= 7) begin
        n = is_wr ? $urandom_range(2, 0) : $urandom_range(1, 0);
        pos = e0;
        for (int unsigned i = 0; i <= n; i++) begin
          if (i > 0) pos = pos + $urandom_range(TMO, 1);
          if (i == n) begin
            put(pos, 8'($urandom), 1'b1);
          end else if (i == 0) begin
            put(pos, cmd, 1'b0);
          end else begin
            d = 8'($urandom); put(pos, d, 1'b0); set_addr(pos, d);
          end
        end
        exp_s[pos] |= S_ER;
        if (n > 0) set_busy(e0, pos - 1);
        t = pos;
      end else begin
        n = $urandom_range(2, 1);
        pos = e0;
        put(e0, cmd, 1'b0);
        if (n == 2) begin
          pos = e0 + $urandom_range(TMO, 1);
          d = 8'($urandom); put(pos, d, 1'b0); set_addr(pos, d);
          if (!is_wr) begin
            exp_s[pos] |= S_RD;
            for (int unsigned j = pos + 1; j <= pos + TMO; j++) begin
              stim[j].lk_rdv = 1'b1;
              if ($urandom_range(5, 0) == 0) put(j, 8'($urandom), 1'($urandom));
            end
          end
        end
        exp_s[pos + TMO] |= S_ER;
        set_busy(e0, pos + TMO - 1);
        t = pos + TMO;
      end
    end
    gen_end = t + 3;
  endtask

  initial begin
    logic [3:0] m_a;
    logic [7:0] m_w, m_t;
    stim_t      s;

    RST = 1'b0;
    RX_D_VLD = 1'b0; RX_ERR = 1'b0; RX_P_DATA = '0;
    RD_DATA_VLD = 1'b0; RD_DATA = '0; TX_BUSY = 1'b0;
    repeat (3) @(posedge REF_CLK);
    #1;
    chk_out("reset_state", S_NO, 4'h0, 8'h00, 8'h00);
    RST = 1'b1;

    // ---------------- directed vector table ----------------
    row(1,0,8'hAA,0,8'h00,0, S_BZ,        4'h0,8'h00,8'h00);
    row(1,0,8'h05,0,8'h00,0, S_BZ,        4'h5,8'h00,8'h00);
    row(0,0,8'h00,0,8'h00,0, S_BZ,        4'h5,8'h00,8'h00);
    row(1,0,8'hA6,0,8'h00,0, S_WR,        4'h5,8'hA6,8'h00);
    row(0,0,8'h00,0,8'h00,0, S_NO,        4'h5,8'hA6,8'h00);
    row(1,0,8'hBB,0,8'h00,0, S_BZ,        4'h5,8'hA6,8'h00);
    row(1,0,8'h03,0,8'h00,0, S_RD | S_BZ, 4'h3,8'hA6,8'h00);
    row(0,0,8'h00,0,8'h00,0, S_BZ,        4'h3,8'hA6,8'h00);
    row(0,0,8'h00,0,8'h00,0, S_BZ,        4'h3,8'hA6,8'h00);
    row(0,0,8'h00,0,8'h00,0, S_BZ,        4'h3,8'hA6,8'h00);
    row(0,0,8'h00,1,8'h5C,0, S_BZ,        4'h3,8'hA6,8'h5C);
    row(0,0,8'h00,0,8'h00,0, S_TX,        4'h3,8'hA6,8'h5C);
    row(1,0,8'h33,0,8'h00,0, S_ER,        4'h3,8'hA6,8'h5C);
    row(1,0,8'hAA,0,8'h00,0, S_BZ,        4'h3,8'hA6,8'h5C);
    row(1,1,8'h02,0,8'h00,0, S_ER,        4'h3,8'hA6,8'h5C);
    row(1,0,8'h07,0,8'h00,0, S_ER,        4'h3,8'hA6,8'h5C);
    row(1,0,8'hAA,0,8'h00,0, S_BZ,        4'h3,8'hA6,8'h5C);
    row(1,0,8'h02,0,8'h00,0, S_BZ,        4'h2,8'hA6,8'h5C);
    row(1,0,8'h11,0,8'h00,0, S_WR,        4'h2,8'h11,8'h5C);
    row(1,1,8'hAA,0,8'h00,0, S_ER,        4'h2,8'h11,8'h5C);
    row(1,0,8'hBB,0,8'h00,0, S_BZ,        4'h2,8'h11,8'h5C);
    row(1,0,8'h19,0,8'h00,0, S_RD | S_BZ, 4'h9,8'h11,8'h5C);
    row(1,0,8'h41,1,8'h77,0, S_BZ,        4'h9,8'h11,8'h77);
    row(0,0,8'h00,0,8'h00,1, S_BZ,        4'h9,8'h11,8'h77);
    row(0,0,8'h00,0,8'h00,1, S_BZ,        4'h9,8'h11,8'h77);
    row(0,0,8'h00,0,8'h00,0, S_TX,        4'h9,8'h11,8'h77);
    row(1,0,8'hBB,0,8'h00,0, S_BZ,        4'h9,8'h11,8'h77);
    row(1,1,8'h0E,0,8'h00,0, S_ER,        4'h9,8'h11,8'h77);
    row(0,0,8'h00,0,8'h00,0, S_NO,        4'h9,8'h11,8'h77);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vld, vecs[i].err, vecs[i].d, vecs[i].rdv, vecs[i].rdd, vecs[i].txb);
      chk_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].w, vecs[i].t);
    end

    // ---------------- write with the widest legal byte spacing ----------------
    drive(1, 0, 8'hAA, 0, 8'h00, 0); chk_out("wgap_cmd", S_BZ, 4'h9, 8'h11, 8'h77);
    idle_chk(TMO - 1, "wgap_a", S_BZ, 4'h9, 8'h11, 8'h77, 1'b0);
    drive(1, 0, 8'h05, 0, 8'h00, 0); chk_out("wgap_addr", S_BZ, 4'h5, 8'h11, 8'h77);
    idle_chk(TMO - 1, "wgap_b", S_BZ, 4'h5, 8'h11, 8'h77, 1'b0);
    drive(1, 0, 8'hA6, 0, 8'h00, 0); chk_out("wgap_wr", S_WR, 4'h5, 8'hA6, 8'h77);
    idle_chk(3, "wgap_after", S_NO, 4'h5, 8'hA6, 8'h77, 1'b0);

    // ---------------- read with TX_BUSY held high ----------------
    drive(1, 0, 8'hBB, 0, 8'h00, 0); chk_out("rbusy_cmd", S_BZ, 4'h5, 8'hA6, 8'h77);
    drive(1, 0, 8'h03, 0, 8'h00, 0); chk_out("rbusy_rd", S_RD | S_BZ, 4'h3, 8'hA6, 8'h77);
    idle_chk(3, "rbusy_wait", S_BZ, 4'h3, 8'hA6, 8'h77, 1'b0);
    drive(0, 0, 8'h00, 1, 8'h5C, 1); chk_out("rbusy_data", S_BZ, 4'h3, 8'hA6, 8'h5C);
    idle_chk(50, "rbusy_hold", S_BZ, 4'h3, 8'hA6, 8'h5C, 1'b1);
    idle_chk(1, "rbusy_tx", S_TX, 4'h3, 8'hA6, 8'h5C, 1'b0);
    idle_chk(2, "rbusy_after", S_NO, 4'h3, 8'hA6, 8'h5C, 1'b0);

    // ---------------- timeout, and a byte landing on the expiry cycle ----------------
    drive(1, 0, 8'hAA, 0, 8'h00, 0); chk_out("tmo_cmd", S_BZ, 4'h3, 8'hA6, 8'h5C);
    idle_chk(TMO - 1, "tmo_wait", S_BZ, 4'h3, 8'hA6, 8'h5C, 1'b0);
    idle_chk(1, "tmo_err", S_ER, 4'h3, 8'hA6, 8'h5C, 1'b0);
    idle_chk(1, "tmo_after", S_NO, 4'h3, 8'hA6, 8'h5C, 1'b0);
    drive(1, 0, 8'hAA, 0, 8'h00, 0); chk_out("exp_cmd", S_BZ, 4'h3, 8'hA6, 8'h5C);
    idle_chk(TMO - 1, "exp_wait", S_BZ, 4'h3, 8'hA6, 8'h5C, 1'b0);
    drive(1, 0, 8'h0D, 0, 8'h00, 0); chk_out("exp_byte", S_BZ, 4'hD, 8'hA6, 8'h5C);
    drive(1, 0, 8'h3C, 0, 8'h00, 0); chk_out("exp_wr", S_WR, 4'hD, 8'h3C, 8'h5C);

    // ---------------- asynchronous reset mid-frame ----------------
    drive(1, 0, 8'hAA, 0, 8'h00, 0); chk_out("rst_cmd", S_BZ, 4'hD, 8'h3C, 8'h5C);
    drive(1, 0, 8'h0C, 0, 8'h00, 0); chk_out("rst_addr", S_BZ, 4'hC, 8'h3C, 8'h5C);
    #3 RST = 1'b0;
    #1 chk_out("rst_async", S_NO, 4'h0, 8'h00, 8'h00);
    @(posedge REF_CLK);
    #1 chk_out("rst_hold", S_NO, 4'h0, 8'h00, 8'h00);
    RST = 1'b1;
    drive(1, 0, 8'h55, 0, 8'h00, 0); chk_out("rst_discard", S_ER, 4'h0, 8'h00, 8'h00);
    idle_chk(1, "rst_after", S_NO, 4'h0, 8'h00, 8'h00, 1'b0);

    // ---------------- randomized frame timeline ----------------
    gen();
    RST = 1'b0;
    @(posedge REF_CLK);
    #1 chk_out("rnd_reset", S_NO, 4'h0, 8'h00, 8'h00);
    RST = 1'b1;
    m_a = '0; m_w = '0; m_t = '0;
    for (int unsigned j = 0; j < gen_end && j < MAXC; j++) begin
      s = stim[j];
      drive(s.vld,
            s.vld ? s.err : 1'($urandom),
            s.vld ? s.d : 8'($urandom),
            s.lk_rdv ? s.rdv : ($urandom_range(7, 0) == 0),
            s.rdv ? s.rdd : 8'($urandom),
            s.lk_txb ? s.txb : ($urandom_range(2, 0) == 0));
      if (up_a[j]) m_a = up_av[j];
      if (up_w[j]) m_w = up_wv[j];
      if (up_t[j]) m_t = up_tv[j];
      chk_out($sformatf("rnd%0d", j), exp_s[j], m_a, m_w, m_t);
      if (errors > 40) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_cmd_decoder.md
Name: sys_cmd_decoder

Overview:
Responder side of the UART command protocol. Consumes received bytes from the UART RX path in the REF_CLK domain and parses command frames: 0xAA = register write (cmd, addr, data) and 0xBB = register read (cmd, addr). It drives register-file write and read strobes, returns read data to the UART TX path, and recovers from bad or stalled frames via error abort and inter-byte timeout.

Parameters:
DATA_WIDTH, 8, width of UART payload bytes and register data
ADDR_WIDTH, 4, register-file address width; the low ADDR_WIDTH bits of the address byte are used
TIMEOUT_CYCLES, 16384, REF_CLK cycles allowed between bytes of one frame, and for read-data return, before abort (must be >= 2)

Ports:
REF_CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
RX_P_DATA  input  DATA_WIDTH  received byte, valid while RX_D_VLD=1
RX_D_VLD  input  1  single-cycle pulse per received byte, already synchronized to REF_CLK
RX_ERR  input  1  parity or stop error on the byte qualified by RX_D_VLD
WR_EN  output  1  register-file write strobe, one cycle
RD_EN  output  1  register-file read strobe, one cycle
ADDR  output  ADDR_WIDTH  register-file address
WR_DATA  output  DATA_WIDTH  register-file write data
RD_DATA  input  DATA_WIDTH  register-file read data
RD_DATA_VLD  input  1  read data valid pulse
TX_P_DATA  output  DATA_WIDTH  response byte to UART TX
TX_D_VLD  output  1  response byte strobe, one cycle
TX_BUSY  input  1  UART TX busy; no strobe is issued while high
CMD_ERR  output  1  one-cycle pulse on any aborted or illegal frame
BUSY  output  1  high whenever FSM is not in IDLE

Behaviour:
- Reset (RST=0, asynchronous): FSM=IDLE, all outputs 0, timeout counter 0, all internal latches 0. Reset applied mid-frame discards the frame with no strobe and no CMD_ERR.
- All outputs are registered. Strobes appear in the cycle after the qualifying input.
- IDLE: on RX_D_VLD with RX_ERR=0: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other value -> stay in IDLE and pulse CMD_ERR.
- WR_ADDR: on RX_D_VLD, latch ADDR <= RX_P_DATA[ADDR_WIDTH-1:0] and go to WR_DATA.
- WR_DATA: on RX_D_VLD, set WR_DATA <= byte and WR_EN=1 for exactly one cycle, then go to IDLE.
- RD_ADDR: on RX_D_VLD, latch ADDR, set RD_EN=1 for one cycle, then go to RD_WAIT.
- RD_WAIT: on RD_DATA_VLD, capture RD_DATA into TX_P_DATA and go to TX_SEND.
- TX_SEND: when TX_BUSY=0, set TX_D_VLD=1 for one cycle, then go to IDLE. If TX_BUSY stays high, wait indefinitely with no timeout.
- RX_ERR=1 with RX_D_VLD in any state that accepts bytes: discard the byte, pulse CMD_ERR, go to IDLE, and emit no WR_EN or RD_EN.
- RX_D_VLD in RD_WAIT or TX_SEND: ignored, with no error.
- Timeout:
  - Counter clears on entry to WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT, and on every accepted byte.
  - Counter increments each cycle in those states.
  - When the count reaches TIMEOUT_CYCLES-1 with no event: pulse CMD_ERR and go to IDLE.
  - An event arriving on the expiry cycle wins over the timeout.
- ADDR and WR_DATA hold their last values between frames. TX_P_DATA holds its value after the strobe.
- Byte arriving on the same cycle the FSM returns to IDLE: evaluated by IDLE on the following cycle only if RX_D_VLD is pulsed again. The single-cycle byte is processed by the state it arrives in.

Test Plan:
- Write frame AA, 05, A6 (RX_D_VLD pulses spaced 100 cycles) -> exactly one WR_EN cycle, ADDR=5, WR_DATA=A6 on the cycle after the third pulse; BUSY falls; CMD_ERR never set.
- Read frame BB, 03; bench returns RD_DATA=5C with RD_DATA_VLD 4 cycles after RD_EN; TX_BUSY=0 -> one RD_EN with ADDR=3, then one TX_D_VLD with TX_P_DATA=5C.
- Read with TX_BUSY held high for 50 cycles after data return -> TX_D_VLD stays 0 until the cycle after TX_BUSY falls, then pulses once.
- Illegal command 0x33 in IDLE -> one CMD_ERR pulse, no strobes; a following AA, 02, 11 write completes normally.
- AA, then address byte with RX_ERR=1 -> CMD_ERR pulse, return to IDLE, no WR_EN; the next byte 0x07 is treated as a command and flagged illegal.
- TIMEOUT_CYCLES=20: send AA then nothing -> CMD_ERR exactly 20 cycles after entering WR_ADDR, BUSY low. Repeat with a byte on the expiry cycle -> no CMD_ERR, FSM reaches WR_DATA. Assert RST mid-frame -> all outputs 0 immediately.
